// File: rtl/if_icache_fetch_if.sv
// Instruction-side memory port of the fetch stage: one-word read request/response.
// The master modport is the fetch stage; the slave modport is the memory controller.
interface if_icache_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_busy_in;
  logic              mem_done_in;
  logic [DATA_W-1:0] mem_data_in;

  modport master (
    output mem_req_out,
    output mem_addr_out,
    input  mem_busy_in,
    input  mem_done_in,
    input  mem_data_in
  );

  modport slave (
    input  mem_req_out,
    input  mem_addr_out,
    output mem_busy_in,
    output mem_done_in,
    output mem_data_in
  );
endinterface

// File: rtl/if_icache_fetch.sv
// Instruction fetch stage with a direct-mapped multi-word-line I-cache and word-by-word refill.
// Optional macro ICACHE_INVALIDATE_EN adds fence_i_in, which invalidates every line.
module if_icache_fetch #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall_in,
  input  logic              branch_flag_in,
`ifdef ICACHE_INVALIDATE_EN
  input  logic              fence_i_in,
`endif
  if_icache_fetch_if.master mem,
  output logic              stall_req_from_if,
  output logic              if_valid_out,
  output logic [ADDR_W-1:0] if_pc_out,
  output logic [DATA_W-1:0] if_inst_out
);

  localparam int IDX   = $clog2(LINES);
  localparam int OFF   = $clog2(LINE_WORDS) + 2;
  localparam int WB    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int TAG_W = ADDR_W - OFF - IDX;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL_DONE} state_t;

  state_t            state_reg, state_next;
  logic [WB-1:0]     cnt_reg, cnt_next;
  logic [ADDR_W-1:0] base_reg, base_next;

  logic              valid_reg [LINES];
  logic [TAG_W-1:0]  tag_mem   [LINES];
  logic [DATA_W-1:0] data_mem  [LINES][LINE_WORDS];

  logic [IDX-1:0]    pc_idx, base_idx;
  logic [WB-1:0]     pc_word;
  logic [TAG_W-1:0]  pc_tag, base_tag;
  logic              hit;
  logic              out_load, out_clear, commit, fill_we, inval_all;
`ifdef ICACHE_INVALIDATE_EN
  logic              fence_now;
  logic              fence_pend_reg;
`endif

  assign pc_idx   = IDX'(pc >> OFF);
  assign pc_word  = WB'((pc >> 2) & ADDR_W'(LINE_WORDS - 1));
  assign pc_tag   = TAG_W'(pc >> (OFF + IDX));
  assign base_idx = IDX'(base_reg >> OFF);
  assign base_tag = TAG_W'(base_reg >> (OFF + IDX));

  assign hit = valid_reg[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  // The refill address lives in base_reg, so a redirect mid-refill cannot corrupt the line.
  assign mem.mem_addr_out = base_reg | (ADDR_W'(cnt_reg) << 2);
  assign mem.mem_req_out  = (state_reg == S_REQ) && !mem.mem_busy_in;
  assign fill_we          = (state_reg == S_WAIT) && mem.mem_done_in;

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    base_next         = base_reg;
    stall_req_from_if = 1'b1;
    out_load          = 1'b0;
    out_clear         = 1'b0;
    commit            = 1'b0;
`ifdef ICACHE_INVALIDATE_EN
    fence_now         = 1'b0;
`endif
    unique case (state_reg)
      S_IDLE: begin
        stall_req_from_if = 1'b0;
`ifdef ICACHE_INVALIDATE_EN
        if (fence_i_in) begin
          stall_req_from_if = 1'b1;
          out_clear         = 1'b1;
          fence_now         = 1'b1;
        end else
`endif
        if (!stall_in) begin
          if (branch_flag_in) begin
            out_clear = 1'b1;
          end else if (hit) begin
            out_load = 1'b1;
          end else begin
            stall_req_from_if = 1'b1;
            out_clear         = 1'b1;
            base_next         = pc & ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
            cnt_next          = '0;
            state_next        = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (!mem.mem_busy_in) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem.mem_done_in) begin
          if (cnt_reg == WB'(LINE_WORDS - 1)) begin
            state_next = S_FILL_DONE;
          end else begin
            cnt_next   = cnt_reg + WB'(1);
            state_next = S_REQ;
          end
        end
      end
      S_FILL_DONE: begin
        commit     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      base_reg  <= base_next;
    end
  end

`ifdef ICACHE_INVALIDATE_EN
  // A fence seen during a refill is remembered and replaces the valid-set at commit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fence_pend_reg <= 1'b0;
    end else if (state_reg == S_FILL_DONE) begin
      fence_pend_reg <= 1'b0;
    end else if (state_reg != S_IDLE && fence_i_in) begin
      fence_pend_reg <= 1'b1;
    end
  end
  assign inval_all = fence_now || (commit && (fence_pend_reg || fence_i_in));
`else
  assign inval_all = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk_in) begin
        if (rst_in || inval_all) begin
          valid_reg[gi] <= 1'b0;
        end else if (commit && base_idx == IDX'(gi)) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (fill_we) data_mem[base_idx][cnt_reg] <= mem.mem_data_in;
    if (commit)  tag_mem[base_idx]           <= base_tag;
  end

  // if_inst_out doubles as the registered read port of the data array.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      if_valid_out <= 1'b0;
      if_pc_out    <= '0;
      if_inst_out  <= '0;
    end else if (out_load) begin
      if_valid_out <= 1'b1;
      if_pc_out    <= pc;
      if_inst_out  <= data_mem[pc_idx][pc_word];
    end else if (out_clear) begin
      if_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_icache_fetch.sv
// Directed and randomized bench for if_icache_fetch: memory responder plus a line-level cache model.
module tb_if_icache_fetch;
  localparam int LINES = 64;
  localparam int LW    = 4;
  localparam int LINE_BYTES = LW * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in = 1'b1;
  logic        stall_in = 1'b1;
  logic        branch_flag_in = 1'b0;
  logic [31:0] pc = '0;
`ifdef ICACHE_INVALIDATE_EN
  logic        fence_i_in = 1'b0;
`endif
  logic        stall_req_from_if, if_valid_out;
  logic [31:0] if_pc_out, if_inst_out;

  if_icache_fetch_if #(.ADDR_W(32), .DATA_W(32)) mem_bus();

  if_icache_fetch #(.ADDR_W(32), .DATA_W(32), .LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .pc                (pc),
    .stall_in          (stall_in),
    .branch_flag_in    (branch_flag_in),
`ifdef ICACHE_INVALIDATE_EN
    .fence_i_in        (fence_i_in),
`endif
    .mem               (mem_bus),
    .stall_req_from_if (stall_req_from_if),
    .if_valid_out      (if_valid_out),
    .if_pc_out         (if_pc_out),
    .if_inst_out       (if_inst_out)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] req_log[$];
  logic [31:0] exp_q[$];
  int          lat = 2;
  bit          busy_force = 1'b0;
  bit          busy_rand = 1'b0;
  bit          mvalid [LINES];
  logic [31:0] mtag   [LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_00A0 + (a >> 2);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  // Returns 1 on a miss, queueing the line's word addresses and marking the line resident.
  function automatic bit model_access(input logic [31:0] p);
    int          idx  = int'((p / LINE_BYTES) % LINES);
    logic [31:0] tag  = p / (LINE_BYTES * LINES);
    logic [31:0] base = p - (p % LINE_BYTES);
    if (mvalid[idx] && mtag[idx] == tag) return 1'b0;
    for (int k = 0; k < LW; k++) exp_q.push_back(base + 32'(k * 4));
    mvalid[idx] = 1'b1;
    mtag[idx]   = tag;
    return 1'b1;
  endfunction

  // Memory controller: optional busy, configurable latency, one-cycle done pulse.
  initial begin
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    mem_bus.mem_busy_in = 1'b0;
    mem_bus.mem_done_in = 1'b0;
    mem_bus.mem_data_in = '0;
    forever begin
      @(negedge clk);
      mem_bus.mem_done_in = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          mem_bus.mem_done_in = 1'b1;
          mem_bus.mem_data_in = mem_word(paddr);
          pend = 1'b0;
        end
      end
      mem_bus.mem_busy_in = busy_force || (busy_rand && ($urandom_range(0, 2) == 0));
      #2;
      if (mem_bus.mem_req_out === 1'b1) begin
        check("req_while_busy", 64'(mem_bus.mem_busy_in), 64'd0);
        req_log.push_back(mem_bus.mem_addr_out);
        paddr = mem_bus.mem_addr_out;
        cnt   = lat;
        pend  = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_first_req();
    int n = 0;
    while (req_log.size() == 0 && n < 50) begin
      step();
      n++;
    end
    check("first_req_timeout", 64'(req_log.size() > 0), 64'd1);
  endtask

  task automatic complete(input logic [31:0] p);
    int n = 0;
    while (stall_req_from_if === 1'b1 && n < 400) begin
      step();
      n++;
      check("fill_valid_low", 64'(if_valid_out), 64'd0);
    end
    check("fill_timeout", 64'(n < 400), 64'd1);
    step();
    check("out_valid", 64'(if_valid_out), 64'd1);
    check("out_pc", 64'(if_pc_out), 64'(p));
    check("out_inst", 64'(if_inst_out), 64'(mem_word({p[31:2], 2'b00})));
    check("req_count", 64'(req_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check("req_addr", 64'((i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF), 64'(exp_q[i]));
  endtask

  task automatic fetch(input logic [31:0] p, input int busy_cycles);
    bit miss;
    req_log.delete();
    exp_q.delete();
    miss = model_access(p);
    if (busy_cycles > 0) begin
      busy_force = 1'b1;
      step();
    end
    pc = p;
    stall_in = 1'b0;
    branch_flag_in = 1'b0;
    #1;
    check("first_stall", 64'(stall_req_from_if), 64'(miss));
    for (int i = 0; i < busy_cycles; i++) begin
      step();
      check("busy_no_req", 64'(mem_bus.mem_req_out), 64'd0);
      check("busy_stall", 64'(stall_req_from_if), 64'd1);
    end
    busy_force = 1'b0;
    complete(p);
  endtask

  initial begin
    logic [31:0] p;
    bit          dummy;

    // Reset with stall held so IDLE does not start a miss on pc=0.
    repeat (3) step();
    rst_in = 1'b0;
    step();
    check("rst_valid", 64'(if_valid_out), 64'd0);
    check("rst_pc", 64'(if_pc_out), 64'd0);
    check("rst_inst", 64'(if_inst_out), 64'd0);
    check("rst_req", 64'(mem_bus.mem_req_out), 64'd0);
    check("rst_addr", 64'(mem_bus.mem_addr_out), 64'd0);
    check("rst_stall_req", 64'(stall_req_from_if), 64'd0);
    model_reset();

    // Cold miss, then a hit in the same line.
    lat = 2;
    fetch(32'h0000_0000, 0);
    fetch(32'h0000_0008, 0);

    // Stall on a hit holds the registered outputs.
    req_log.delete();
    stall_in = 1'b1;
    pc = 32'h0000_0004;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_pc", 64'(if_pc_out), 64'h8);
      check("stall_hold_inst", 64'(if_inst_out), 64'(mem_word(32'h8)));
      check("stall_hold_valid", 64'(if_valid_out), 64'd1);
      check("stall_req_idle", 64'(stall_req_from_if), 64'd0);
    end
    check("stall_no_req", 64'(req_log.size()), 64'd0);
    stall_in = 1'b0;

    // Conflict misses on index 0.
    fetch(32'h0000_0400, 0);
    fetch(32'h0000_0000, 0);

    // Branch in IDLE on a missing address: no miss, output invalidated.
    req_log.delete();
    pc = 32'h0000_3330;
    branch_flag_in = 1'b1;
    #1;
    check("branch_idle_stall_req", 64'(stall_req_from_if), 64'd0);
    step();
    branch_flag_in = 1'b0;
    stall_in = 1'b1;
    check("branch_idle_valid", 64'(if_valid_out), 64'd0);
    step();
    check("branch_idle_no_req", 64'(req_log.size()), 64'd0);

    // Memory busy for five cycles in REQ.
    fetch(32'h0000_0050, 5);

    // Branch during WAIT: the current line completes, then the new pc is fetched.
    lat = 3;
    req_log.delete();
    exp_q.delete();
    dummy = model_access(32'h0000_0860);
    pc = 32'h0000_0860;
    stall_in = 1'b0;
    wait_first_req();
    pc = 32'h0000_0100;
    branch_flag_in = 1'b1;
    #1;
    check("branch_wait_stall_req", 64'(stall_req_from_if), 64'd1);
    step();
    branch_flag_in = 1'b0;
    dummy = model_access(32'h0000_0100);
    complete(32'h0000_0100);
    fetch(32'h0000_0864, 0);

    // Reset during WAIT: the late done pulse must be ignored.
    req_log.delete();
    pc = 32'h0000_2000;
    stall_in = 1'b0;
    wait_first_req();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    stall_in = 1'b1;
    check("rst_wait_req", 64'(mem_bus.mem_req_out), 64'd0);
    check("rst_wait_valid", 64'(if_valid_out), 64'd0);
    check("rst_wait_addr", 64'(mem_bus.mem_addr_out), 64'd0);
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_late_req", 64'(mem_bus.mem_req_out), 64'd0);
      check("rst_late_valid", 64'(if_valid_out), 64'd0);
    end
    lat = 2;
    fetch(32'h0000_0000, 0);

`ifdef ICACHE_INVALIDATE_EN
    // Fence in IDLE drops every line; pc=0 then refills fully.
    fetch(32'h0000_0000, 0);
    fence_i_in = 1'b1;
    #1;
    check("fence_stall_req", 64'(stall_req_from_if), 64'd1);
    step();
    fence_i_in = 1'b0;
    check("fence_valid", 64'(if_valid_out), 64'd0);
    model_reset();
    fetch(32'h0000_0000, 0);
`endif

    // Randomized fetches over a small footprint with random busy and latency.
    busy_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      lat = int'($urandom_range(1, 3));
      p = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fetch(p, 0);
    end
    busy_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_icache_fetch.md
Name: if_icache_fetch

Overview:
- Parametrised instruction-fetch stage with a direct-mapped, multi-word-line instruction cache.
- Sits between the PC register and IF/ID. Owns the instruction port of the memory controller.
- Successor to the single-word fetch stage. It adds configurable line size and depth, valid bits cleared by reset, a registered miss/refill FSM with word-by-word line fill, registered outputs, a downstream stall hold, and branch flush during refill.

Parameters:
ADDR_W, 32, address/PC width in bits
DATA_W, 32, instruction word width; fixed at 32 (byte offset 2 bits)
LINES, 64, number of cache lines; power of 2, >=2
LINE_WORDS, 4, words per line; power of 2, >=1

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  synchronous reset, active-high
pc  input  ADDR_W  fetch address; bits [1:0] ignored
stall_in  input  1  downstream stall; hold registered outputs
branch_flag_in  input  1  branch/jump redirect; discard the fetch of this cycle
mem_busy_in  input  1  memory controller serving another port; do not issue a request
mem_done_in  input  1  one-cycle pulse; mem_data_in valid
mem_data_in  input  DATA_W  returned word
mem_req_out  output  1  one-cycle word-read request
mem_addr_out  output  ADDR_W  word address of the request, word aligned
stall_req_from_if  output  1  combinational; fetch cannot deliver pc this cycle
if_valid_out  output  1  registered; if_pc_out/if_inst_out hold a valid instruction
if_pc_out  output  ADDR_W  registered fetched PC
if_inst_out  output  DATA_W  registered fetched instruction

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS) + 2.
  - IDX = log2(LINES).
  - index = pc[OFF+IDX-1:OFF]; word = pc[OFF-1:2]; tag = pc[ADDR_W-1:OFF+IDX].
- Storage: data array LINES x LINE_WORDS x DATA_W; tag array; valid bit per line.
- Reset (rst_in=1 at an edge):
  - All valid bits cleared; FSM to IDLE; word counter cleared.
  - mem_req_out=0, mem_addr_out=0, if_valid_out=0, if_pc_out=0, if_inst_out=0.
  - Applies mid-refill: any late mem_done_in after reset is ignored.
- hit = valid[index] && tag_array[index]==tag. Combinational, in IDLE only.
- States:
  - IDLE: lookup.
  - REQ: wait until mem_busy_in=0, then issue the request.
  - WAIT: wait for mem_done_in.
  - FILL_DONE: commit tag/valid.
- IDLE, stall_in=1: outputs held; no lookup; no miss started; stall_req_from_if=0.
- IDLE, branch_flag_in=1: if_valid_out<=0 next edge; no miss started; stall_req_from_if=0.
- IDLE, hit (stall_in=0, branch_flag_in=0): next edge if_valid_out<=1, if_pc_out<=pc, if_inst_out<=data[index][word]. Hit latency is 1 cycle; stall_req_from_if=0.
- IDLE, miss (stall_in=0, branch_flag_in=0): latch the line base address, pc with bits [OFF-1:0] zeroed; counter<=0; go to REQ; if_valid_out<=0; stall_req_from_if=1.
- REQ: mem_addr_out = base + counter*4.
  - If mem_busy_in=0: mem_req_out=1 for exactly this cycle, then WAIT.
  - Else hold in REQ with mem_req_out=0.
- WAIT: on mem_done_in, write mem_data_in into data[base index][counter].
  - counter==LINE_WORDS-1 → FILL_DONE.
  - Else counter+1, back to REQ.
  - mem_addr_out held throughout WAIT.
- FILL_DONE: write tag, set valid, go to IDLE. The next IDLE cycle re-looks-up the current pc.
- stall_req_from_if=1 in all states except IDLE. In IDLE it is 1 only on a miss.
- Branch during REQ/WAIT/FILL_DONE: the refill runs to completion. Its address is latched, so the line stays correct. if_valid_out stays 0. The new pc is looked up in IDLE.
- Words are written only on mem_done_in while in WAIT. The line is never marked valid until all words are written.
- A replaced line is overwritten; no write-back; the cache is read-only.

Optional Feature:
- Macro: ICACHE_INVALIDATE_EN.
- When defined:
  - Adds input fence_i_in (1 bit).
  - In IDLE, fence_i_in=1 clears all valid bits at the next edge and suppresses that cycle's lookup (if_valid_out<=0, stall_req_from_if=1).
  - In other states it is latched. The clear is applied in the FILL_DONE cycle instead of setting valid.
- When undefined: port absent; valid bits are cleared only by reset.

Test Plan:
1. Cold miss, LINES=64, LINE_WORDS=4: reset, pc=0x0, mem returns 0xA0..0xA3 after 2 cycles each. Required:
   - mem_req_out pulses at addrs 0x0, 0x4, 0x8, 0xC.
   - stall_req_from_if=1 throughout the fill.
   - After FILL_DONE+1 edge: if_valid_out=1, if_pc_out=0x0, if_inst_out=0xA0.
2. Line hit: after test 1, pc=0x8. Required: no mem_req_out; next edge if_inst_out=0xA2; stall_req_from_if=0.
3. Conflict miss: pc=0x400 (index 0, tag 1). Required:
   - Refill at 0x400..0x40C.
   - A later pc=0x0 misses again and refills.
4. Busy and stall: hold mem_busy_in=1 for 5 cycles in REQ. Required:
   - mem_req_out=0 for those cycles; a single pulse after release.
   - Separately, stall_in=1 on a hit keeps if_pc_out/if_inst_out unchanged.
5. Branch and reset mid-refill:
   - branch_flag_in=1 with pc=0x100 during WAIT → the line fill completes, then 0x100 is fetched.
   - rst_in=1 during WAIT → mem_req_out=0, if_valid_out=0, and pc=0x0 misses again.
6. ICACHE_INVALIDATE_EN: after test 1, fence_i_in=1 in IDLE, then pc=0x0. Required: a full 4-word refill is issued.
